// File: rtl/io_uart_tx.sv
// rtl/io_uart_tx.sv - memory-mapped 8N1 UART transmitter on the M-stage IO data path
//
// Purpose: accepts M-stage stores in the IO window, queues TXDATA bytes in a small
// FIFO and serialises them LSB first as 8N1 frames on o_tx. Loads return STATUS or
// BAUD_DIV through a purely combinational read mux.
//
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_clk_en          global clock enable; every state update is qualified by it
//   i_io_en_m         access targets the IO window
//   i_mem_write_m     store in M stage
//   i_mem_addr_m      byte offset within the IO window (bits [3:0] decoded)
//   i_mem_data_m      store data (bits [15:0] used)
//   i_store_byte_m    byte store
//   i_store_half_m    half store
//   o_mem_data_m      read data, zero when i_io_en_m is low
//   o_tx              serial line, idles high
//   o_tx_busy         serializer active or FIFO holding bytes

`ifndef XLEN_64b
`define XLEN_64b 2
`endif

module io_uart_tx #(
    parameter int          XLEN           = `XLEN_64b,
    parameter int          FIFO_DEPTH     = 4,
    parameter logic [15:0] RESET_BAUD_DIV = 16'd16,
    localparam int         DW             = 1 << (XLEN + 4)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clk_en,
    input  logic          i_io_en_m,
    input  logic          i_mem_write_m,
    input  logic [DW-1:0] i_mem_addr_m,
    input  logic [DW-1:0] i_mem_data_m,
    input  logic          i_store_byte_m,
    input  logic          i_store_half_m,
    output logic [DW-1:0] o_mem_data_m,
    output logic          o_tx,
    output logic          o_tx_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic [7:0]    fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          ovf_q;
    logic [15:0]   baud_div_q;

    state_t        state_q;
    logic [7:0]    shift_q;
    logic [2:0]    bit_idx_q;
    logic [15:0]   bit_cnt_q;
    logic          tx_q;

    logic [3:0]    addr;
    logic          we;
    logic          wr_txdata;
    logic          wr_status;
    logic          wr_baud;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          push;
    logic          overflow;
    logic [15:0]   bit_load;
    logic          ser_busy;
    logic [7:0]    status;
    logic          unused_bits;

    assign addr      = i_mem_addr_m[3:0];
    assign we        = i_clk_en & i_io_en_m & i_mem_write_m;
    assign wr_txdata = we & (addr == 4'h0);
    assign wr_status = we & (addr == 4'h4);
    assign wr_baud   = we & (addr == 4'h8);

    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);

    // The serializer takes the head whenever it sits in IDLE with data queued.
    assign pop      = i_clk_en & (state_q == S_IDLE) & ~fifo_empty;
    // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
    assign push     = wr_txdata & (~fifo_full | pop);
    assign overflow = wr_txdata & fifo_full & ~pop;

    // Down-counter reload; a divider of 0 behaves as 1.
    assign bit_load = (baud_div_q == 16'd0) ? 16'd0 : (baud_div_q - 16'd1);

    assign ser_busy  = (state_q != S_IDLE);
    assign o_tx_busy = ser_busy | ~fifo_empty;
    assign o_tx      = tx_q;

    assign status = {4'(count_q), ovf_q, ser_busy, fifo_empty, fifo_full};

    assign unused_bits = ^{i_mem_addr_m[DW-1:4], i_mem_data_m[DW-1:16], i_store_half_m};

    always_comb begin
        o_mem_data_m = '0;
        if (i_io_en_m) begin
            case (addr)
                4'h4:    o_mem_data_m = DW'(status);
                4'h8:    o_mem_data_m = DW'(baud_div_q);
                default: o_mem_data_m = '0;
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is not reset: entries are only ever read behind a valid count.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= i_mem_data_m[7:0];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            baud_div_q <= RESET_BAUD_DIV;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (i_clk_en) begin
                count_q <= count_d;
            end
            if (overflow) begin
                ovf_q <= 1'b1;
            end else if (wr_status) begin
                ovf_q <= 1'b0;
            end
            if (wr_baud) begin
                if (i_store_byte_m) begin
                    baud_div_q[7:0] <= i_mem_data_m[7:0];
                end else begin
                    baud_div_q <= i_mem_data_m[15:0];
                end
            end
        end
    end

    // Serializer: each bit holds for bit_load+1 enabled clocks; the counter is
    // reloaded on every bit entry so a BAUD_DIV change applies from the next bit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
        end else if (i_clk_en) begin
            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (!fifo_empty) begin
                        shift_q   <= fifo_mem_q[rd_ptr_q];
                        bit_cnt_q <= bit_load;
                        tx_q      <= 1'b0;
                        state_q   <= S_START;
                    end
                end
                S_START: begin
                    if (bit_cnt_q == 16'd0) begin
                        bit_cnt_q <= bit_load;
                        bit_idx_q <= 3'd0;
                        tx_q      <= shift_q[0];
                        state_q   <= S_DATA;
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_cnt_q == 16'd0) begin
                        bit_cnt_q <= bit_load;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shift_q   <= {1'b0, shift_q[7:1]};
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_cnt_q == 16'd0) begin
                        tx_q    <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 16'd1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
